spi_flash_responder: RTL and testbench

FPGA-side SPI flash emulator: the responder at the far end of the SoC's SPI flash host port (`spi_flash_sck`, `spi_flash_csb`, `spi_flash_sd[1:0]`). It serves single-lane SPI mode-0 READ, JEDEC-ID and READ-STATUS commands from a byte-wide on-chip memory, so the board can boot or execute from flash without a physical part. It samples SPI pins with the system clock; it has no SCK clock domain.

---
 rtl/spi_flash_responder_pkg.sv | 32 +++
 rtl/spi_pin_sync.sv | 54 +++++
 rtl/spi_flash_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_responder_pkg.sv
// Shared definitions for the SPI flash responder.
//   - Opcodes served: READ (0x03), RDID (0x9F), RDSR (0x05).
//   - spi_resp_state_e: command FSM states.
//   - id_byte(): selects the JEDEC ID byte for a given byte index (0xFF past the third byte).
package spi_flash_responder_pkg;

   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_RDID = 8'h9F;
   localparam logic [7:0] OP_RDSR = 8'h05;

   typedef enum logic [2:0] {
      StIdle,
      StOpcode,
      StAddr,
      StRead,
      StId,
      StStatus,
      StIgnore
   } spi_resp_state_e;

   function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = id[23:16];
         2'd1:    b = id[15:8];
         2'd2:    b = id[7:0];
         default: b = 8'hFF;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes the SPI pins into the system clock domain and derives SCK edge strobes.
// Ports:
//   clk, rst        : system clock, synchronous active-high reset
//   sck, csb, mosi  : raw SPI pins
//   csb_sync        : synchronized chip select (resets to 1 = deselected)
//   mosi_sync       : synchronized host data
//   sck_rise        : one-cycle strobe, SYNC_STAGES+1 cycles after an SCK rise at the pin
//   sck_fall        : one-cycle strobe, SYNC_STAGES+1 cycles after an SCK fall at the pin
module spi_pin_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sck,
   input  logic csb,
   input  logic mosi,
   output logic csb_sync,
   output logic mosi_sync,
   output logic sck_rise,
   output logic sck_fall
);

   logic [SYNC_STAGES-1:0] sck_ff;
   logic [SYNC_STAGES-1:0] csb_ff;
   logic [SYNC_STAGES-1:0] mosi_ff;
   logic                   sck_prev;
   logic                   rise_q;
   logic                   fall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_ff   <= '0;
         csb_ff   <= '1;
         mosi_ff  <= '0;
         sck_prev <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         sck_ff   <= {sck_ff[SYNC_STAGES-2:0], sck};
         csb_ff   <= {csb_ff[SYNC_STAGES-2:0], csb};
         mosi_ff  <= {mosi_ff[SYNC_STAGES-2:0], mosi};
         sck_prev <= sck_ff[SYNC_STAGES-1];
         // Strobes are registered so they line up one cycle after the last sync stage.
         rise_q   <= sck_ff[SYNC_STAGES-1] & ~sck_prev;
         fall_q   <= ~sck_ff[SYNC_STAGES-1] & sck_prev;
      end
   end

   assign csb_sync  = csb_ff[SYNC_STAGES-1];
   assign mosi_sync = mosi_ff[SYNC_STAGES-1];
   assign sck_rise  = rise_q;
   assign sck_fall  = fall_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI flash emulator (mode 0, single lane) serving READ, RDID and RDSR from a byte-wide memory.
// SPI pins are oversampled with clk_i; there is no SCK clock domain.
// Ports:
//   clk_i, rst_i               : system clock, synchronous active-high reset
//   spi_sck_i, spi_csb_i       : SPI clock and active-low chip select from the host
//   spi_mosi_i                 : host data (sd[0])
//   spi_miso_o, spi_miso_oe_o  : responder data (sd[1]) and its pad output enable
//   mem_req_o, mem_addr_o      : one-cycle read strobe and byte address
//   mem_rdata_i                : read data, valid the cycle after mem_req_o
//   cmd_active_o               : synchronized chip select is low
//   cmd_error_o                : one-cycle pulse on an unsupported opcode
module spi_flash_responder
   import spi_flash_responder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  spi_sck_i,
   input  logic                  spi_csb_i,
   input  logic                  spi_mosi_i,
   output logic                  spi_miso_o,
   output logic                  spi_miso_oe_o,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic [7:0]            mem_rdata_i,
   output logic                  cmd_active_o,
   output logic                  cmd_error_o
);

   logic csb_s;
   logic mosi_s;
   logic sck_rise_raw;
   logic sck_fall_raw;
   logic rise;
   logic fall;

   spi_pin_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_pin_sync (
      .clk       (clk_i),
      .rst       (rst_i),
      .sck       (spi_sck_i),
      .csb       (spi_csb_i),
      .mosi      (spi_mosi_i),
      .csb_sync  (csb_s),
      .mosi_sync (mosi_s),
      .sck_rise  (sck_rise_raw),
      .sck_fall  (sck_fall_raw)
   );

   // SCK activity while deselected is meaningless.
   assign rise = sck_rise_raw & ~csb_s;
   assign fall = sck_fall_raw & ~csb_s;

   spi_resp_state_e       state_q, state_d;
   logic [2:0]            bit_cnt_q, bit_cnt_d;     // rises within the current byte
   logic [4:0]            addr_cnt_q, addr_cnt_d;   // address bits received
   logic [6:0]            op_q, op_d;               // first 7 opcode bits
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;   // address shifter, then read pointer
   logic                  mem_req_q, mem_req_d;
   logic                  pend_q, pend_d;           // mem_rdata_i is valid this cycle
   logic [7:0]            prefetch_q, prefetch_d;
   logic [6:0]            shift_q, shift_d;         // bits still to send after miso_q
   logic                  miso_q, miso_d;
   logic [1:0]            id_idx_q, id_idx_d;
   logic                  cmd_error_q, cmd_error_d;

   logic [7:0]            opcode;
   logic [7:0]            src;

   assign opcode = {op_q, mosi_s};

   always_comb begin
      src = 8'h00;
      unique case (state_q)
         StRead:  src = prefetch_q;
         StId:    src = id_byte(JEDEC_ID, id_idx_q);
         default: src = 8'h00;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      addr_cnt_d  = addr_cnt_q;
      op_d        = op_q;
      mem_addr_d  = mem_addr_q;
      mem_req_d   = 1'b0;
      pend_d      = mem_req_q;
      prefetch_d  = prefetch_q;
      shift_d     = shift_q;
      miso_d      = miso_q;
      id_idx_d    = id_idx_q;
      cmd_error_d = 1'b0;

      if (csb_s) begin
         // Deselect aborts everything, including a fetch whose data is still in flight.
         state_d    = StIdle;
         bit_cnt_d  = '0;
         addr_cnt_d = '0;
         op_d       = '0;
         pend_d     = 1'b0;
         shift_d    = '0;
         miso_d     = 1'b0;
         id_idx_d   = '0;
      end else begin
         if (pend_q) begin
            prefetch_d = mem_rdata_i;
         end
         unique case (state_q)
            StIdle: begin
               state_d   = StOpcode;
               bit_cnt_d = '0;
            end
            StOpcode: begin
               if (rise) begin
                  op_d      = opcode[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     case (opcode)
                        OP_READ: begin
                           state_d    = StAddr;
                           addr_cnt_d = '0;
                        end
                        OP_RDID: begin
                           state_d  = StId;
                           id_idx_d = '0;
                        end
                        OP_RDSR: state_d = StStatus;
                        default: begin
                           state_d     = StIgnore;
                           cmd_error_d = 1'b1;
                        end
                     endcase
                  end
               end
            end
            StAddr: begin
               if (rise && addr_cnt_q != 5'd24) begin
                  // Only the low ADDR_WIDTH bits survive the shift.
                  mem_addr_d = {mem_addr_q[ADDR_WIDTH-2:0], mosi_s};
                  addr_cnt_d = addr_cnt_q + 5'd1;
                  if (addr_cnt_q == 5'd23) begin
                     mem_req_d = 1'b1;
                  end
               end
               if (pend_q) begin
                  state_d   = StRead;
                  bit_cnt_d = '0;
               end
            end
            StRead, StId, StStatus: begin
               if (rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
               if (fall) begin
                  if (bit_cnt_q == 3'd0) begin
                     // Byte boundary: present the next byte MSB first.
                     miso_d  = src[7];
                     shift_d = src[6:0];
                     if (state_q == StRead) begin
                        mem_addr_d = mem_addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        mem_req_d  = 1'b1;
                     end
                     if (state_q == StId && id_idx_q != 2'd3) begin
                        id_idx_d = id_idx_q + 2'd1;
                     end
                  end else begin
                     miso_d  = shift_q[6];
                     shift_d = {shift_q[5:0], 1'b0};
                  end
               end
            end
            StIgnore: state_d = StIgnore;
            default:  state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         addr_cnt_q  <= '0;
         op_q        <= '0;
         mem_addr_q  <= '0;
         mem_req_q   <= 1'b0;
         pend_q      <= 1'b0;
         prefetch_q  <= '0;
         shift_q     <= '0;
         miso_q      <= 1'b0;
         id_idx_q    <= '0;
         cmd_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         addr_cnt_q  <= addr_cnt_d;
         op_q        <= op_d;
         mem_addr_q  <= mem_addr_d;
         mem_req_q   <= mem_req_d;
         pend_q      <= pend_d;
         prefetch_q  <= prefetch_d;
         shift_q     <= shift_d;
         miso_q      <= miso_d;
         id_idx_q    <= id_idx_d;
         cmd_error_q <= cmd_error_d;
      end
   end

   assign spi_miso_o    = miso_q;
   assign spi_miso_oe_o = ~csb_s & (state_q inside {StRead, StId, StStatus});
   assign mem_req_o     = mem_req_q;
   assign mem_addr_o    = mem_addr_q;
   assign cmd_active_o  = ~csb_s;
   assign cmd_error_o   = cmd_error_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: a bit-level SPI host, a byte memory that answers
// one cycle after each request, and a byte-level reference model of what each command returns.
module tb_spi_flash_responder;
   import spi_flash_responder_pkg::*;

   localparam int unsigned AW  = 16;
   localparam int unsigned SS  = 2;
   localparam logic [23:0] JID = 24'hEF4018;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sck = 1'b0;
   logic          csb = 1'b1;
   logic          mosi = 1'b0;
   logic          miso;
   logic          miso_oe;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata = 8'h00;
   logic          cmd_active;
   logic          cmd_error;

   always #5 clk = ~clk;

   spi_flash_responder #(
      .ADDR_WIDTH  (AW),
      .JEDEC_ID    (JID),
      .SYNC_STAGES (SS)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .spi_sck_i     (sck),
      .spi_csb_i     (csb),
      .spi_mosi_i    (mosi),
      .spi_miso_o    (miso),
      .spi_miso_oe_o (miso_oe),
      .mem_req_o     (mem_req),
      .mem_addr_o    (mem_addr),
      .mem_rdata_i   (mem_rdata),
      .cmd_active_o  (cmd_active),
      .cmd_error_o   (cmd_error)
   );

   logic [7:0] mem [0:(1<<AW)-1];
   logic [7:0] rx_bytes [0:15];

   int checks = 0;
   int failures = 0;
   int hp = 4;
   int cyc = 0;
   int req_cnt = 0;
   int err_cnt = 0;
   int oe_cnt = 0;
   int consec_bad = 0;
   int err_cyc = 0;
   int op_rise_cyc = 0;
   int oe_lo = 0;
   logic prev_req = 1'b0;

   // Memory answers exactly one cycle after a request; garbage otherwise.
   always @(posedge clk) begin
      cyc       <= cyc + 1;
      mem_rdata <= mem_req ? mem[mem_addr] : 8'($urandom);
      prev_req  <= mem_req;
      if (mem_req) req_cnt <= req_cnt + 1;
      if (mem_req && prev_req) consec_bad <= consec_bad + 1;
      if (cmd_error) err_cnt <= err_cnt + 1;
      if (miso_oe) oe_cnt <= oe_cnt + 1;
   end

   always @(negedge clk) begin
      if (cmd_error) err_cyc <= cyc;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] model_byte(input logic [7:0] op, input logic [23:0] a,
                                             input int k);
      logic [23:0] jid;
      int          idx;
      jid = JID;
      if (op == OP_READ) begin
         idx = (int'(a) + k) % (1 << AW);
         return mem[idx];
      end
      if (op == OP_RDID) begin
         if (k < 3) return jid[23-8*k -: 8];
         return 8'hFF;
      end
      return 8'h00;
   endfunction

   // One SPI transaction; cut > 0 stops after that many SCK rises. SCK is left high after the
   // final rise and only dropped once CSB is high, so no trailing fall is seen while selected.
   task automatic xfer(input logic [7:0] op, input logic [23:0] a, input int nbytes,
                       input int cut, input bit do_rst);
      int         hdr;
      int         n;
      logic [7:0] rb;
      rb  = 8'h00;
      hdr = (op == OP_READ) ? 32 : 8;
      n   = hdr + 8 * nbytes;
      if (cut > 0 && cut < n) n = cut;
      oe_lo = 0;
      csb = 1'b0;
      sck = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i < 8) mosi = op[7-i];
         else if (i < hdr) mosi = a[23-(i-8)];
         else mosi = 1'($urandom);
         repeat (hp) @(negedge clk);
         if (i >= hdr) begin
            rb = {rb[6:0], miso};
            if (!miso_oe) oe_lo++;
            if (((i - hdr) % 8) == 7) rx_bytes[(i - hdr) / 8] = rb;
         end
         sck = 1'b1;
         if (i == 7) op_rise_cyc = cyc;
         repeat (hp) @(negedge clk);
         if (i != n - 1) sck = 1'b0;
      end
      if (do_rst) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         chk("rst_mid miso", 32'(miso), 32'd0);
         chk("rst_mid oe", 32'(miso_oe), 32'd0);
         chk("rst_mid req", 32'(mem_req), 32'd0);
         chk("rst_mid addr", 32'(mem_addr), 32'd0);
         chk("rst_mid active", 32'(cmd_active), 32'd0);
         chk("rst_mid error", 32'(cmd_error), 32'd0);
      end
      csb = 1'b1;
      repeat (hp) @(negedge clk);
      sck = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic run(input string tag, input logic [7:0] op, input logic [23:0] a,
                      input int nbytes);
      int req0;
      int err0;
      int oe0;
      bit ok_op;
      req0 = req_cnt;
      err0 = err_cnt;
      oe0  = oe_cnt;
      xfer(op, a, nbytes, 0, 1'b0);
      ok_op = (op == OP_READ) || (op == OP_RDID) || (op == OP_RDSR);
      if (ok_op) begin
         for (int k = 0; k < nbytes; k++) begin
            chk($sformatf("%s byte%0d", tag, k), 32'(rx_bytes[k]), 32'(model_byte(op, a, k)));
         end
         chk({tag, " oe_low_samples"}, 32'(oe_lo), 32'd0);
         chk({tag, " req_count"}, 32'(req_cnt - req0),
             (op == OP_READ) ? 32'(nbytes + 1) : 32'd0);
         chk({tag, " err_count"}, 32'(err_cnt - err0), 32'd0);
      end else begin
         chk({tag, " err_count"}, 32'(err_cnt - err0), 32'd1);
         chk({tag, " err_latency"}, 32'(err_cyc - op_rise_cyc), 32'(SS + 2));
         chk({tag, " oe_cycles"}, 32'(oe_cnt - oe0), 32'd0);
         chk({tag, " req_count"}, 32'(req_cnt - req0), 32'd0);
      end
      chk({tag, " idle_active"}, 32'(cmd_active), 32'd0);
   endtask

   initial begin
      int req0;
      logic [7:0]  op;
      logic [23:0] a;
      int          nb;

      for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i);

      repeat (3) @(negedge clk);
      chk("reset miso", 32'(miso), 32'd0);
      chk("reset oe", 32'(miso_oe), 32'd0);
      chk("reset req", 32'(mem_req), 32'd0);
      chk("reset addr", 32'(mem_addr), 32'd0);
      chk("reset active", 32'(cmd_active), 32'd0);
      chk("reset error", 32'(cmd_error), 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      run("read_10", OP_READ, 24'h000010, 4);
      run("read_wrap", OP_READ, 24'h00FFFE, 4);
      run("read_wrap_hi", OP_READ, 24'h12FFFE, 4);
      run("rdid", OP_RDID, 24'h0, 5);
      run("rdsr", OP_RDSR, 24'h0, 2);
      run("bad_ab", 8'hAB, 24'h0, 2);

      // Abort after 13 address bits, then a clean read must start from scratch.
      req0 = req_cnt;
      xfer(OP_READ, 24'hA5C3F1, 4, 8 + 13, 1'b0);
      chk("abort req_count", 32'(req_cnt - req0), 32'd0);
      chk("abort oe", 32'(miso_oe), 32'd0);
      chk("abort active", 32'(cmd_active), 32'd0);
      run("after_abort", OP_READ, 24'h000003, 2);

      // Reset during bit 4 of the first data byte, then a normal read.
      xfer(OP_READ, 24'h000020, 4, 32 + 4, 1'b1);
      run("after_reset", OP_READ, 24'h000040, 3);

      // Randomized traffic against random memory contents.
      for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
      for (int t = 0; t < 10; t++) begin
         hp = int'($urandom_range(6, 4));
         case ($urandom_range(3, 0))
            0:       op = OP_READ;
            1:       op = OP_RDID;
            2:       op = OP_RDSR;
            default: op = 8'($urandom);
         endcase
         if (t < 4) op = OP_READ;
         a  = 24'($urandom);
         nb = int'($urandom_range(6, 1));
         run($sformatf("rand%0d_op%02h", t, op), op, a, nb);
      end

      chk("no_back_to_back_req", 32'(consec_bad), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
